// File: rtl/vc_iter_muldiv.sv
// rtl/vc_iter_muldiv.sv - iterative one-bit-per-cycle multiply/divide unit with val/rdy handshakes
// Shift-add multiply and restoring divide share one accumulator and two shift registers.
module vc_iter_muldiv #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_op,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_result
);

    localparam int N  = p_nbits;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  a_q, a_d;
    logic          b_neg_q, b_neg_d;
    logic          b_zero_q, b_zero_d;
    logic [N-1:0]  result_q, result_d;

    logic          req_signed;
    logic [N-1:0]  a_abs, b_abs;
    logic          is_div;
    logic [N-1:0]  mul_sum;
    logic [N:0]    rem_sh, trial;
    logic [N-1:0]  div_acc, div_x;
    logic [N-1:0]  final_res;

    always_comb begin
        req_signed = (req_op == OP_DIV) || (req_op == OP_REM);
        a_abs      = (req_signed && req_a[N-1]) ? -req_a : req_a;
        b_abs      = (req_signed && req_b[N-1]) ? -req_b : req_b;
        is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);

        mul_sum = acc_q + (y_q[0] ? x_q : '0);
        // Restoring step: the N+1-bit trial borrow decides the quotient bit.
        rem_sh  = {acc_q, x_q[N-1]};
        trial   = rem_sh - {1'b0, y_q};
        div_acc = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
        div_x   = {x_q[N-2:0], ~trial[N]};

        case (op_q)
            OP_MUL:  final_res = mul_sum;
            OP_DIVU: final_res = div_x;
            OP_REMU: final_res = div_acc;
            OP_DIV:  final_res = b_zero_q ? '1 :
                                 ((a_q[N-1] ^ b_neg_q) ? -div_x : div_x);
            OP_REM:  final_res = b_zero_q ? a_q :
                                 (a_q[N-1] ? -div_acc : div_acc);
            default: final_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        a_d      = a_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (req_val) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_neg_d  = req_signed & req_b[N-1];
                    b_zero_d = (req_b == '0);
                    acc_d    = '0;
                    x_d      = a_abs;
                    y_d      = b_abs;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div) begin
                    acc_d = div_acc;
                    x_d   = div_x;
                end else begin
                    acc_d = mul_sum;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            a_q      <= '0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a_q      <= a_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            result_q <= result_d;
        end
    end

    assign req_rdy     = (state_q == S_IDLE);
    assign resp_val    = (state_q == S_DONE);
    assign resp_result = result_q;

endmodule

// File: tb/tb_vc_iter_muldiv.sv
// tb/tb_vc_iter_muldiv.sv - bench for vc_iter_muldiv at 32 and 8 bits
module tb_vc_iter_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_val32, req_rdy32, resp_val32, resp_rdy32;
    logic [2:0]  req_op32;
    logic [31:0] req_a32, req_b32, resp_result32;
    logic        req_val8, req_rdy8, resp_val8, resp_rdy8;
    logic [2:0]  req_op8;
    logic [7:0]  req_a8, req_b8, resp_result8;

    int total  = 0;
    int passed = 0;

    vc_iter_muldiv #(.p_nbits(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_val(req_val32), .req_rdy(req_rdy32), .req_op(req_op32),
        .req_a(req_a32), .req_b(req_b32),
        .resp_val(resp_val32), .resp_rdy(resp_rdy32), .resp_result(resp_result32)
    );

    vc_iter_muldiv #(.p_nbits(8)) dut8 (
        .clk(clk), .reset(reset),
        .req_val(req_val8), .req_rdy(req_rdy8), .req_op(req_op8),
        .req_a(req_a8), .req_b(req_b8),
        .resp_val(resp_val8), .resp_rdy(resp_rdy8), .resp_result(resp_result8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Arithmetic reference: signed views via sign extension, plain / and % on 64-bit ints.
    function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, rr;
        longint ua, ub, sa, sb, r;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'({32'b0, a} & mask);
        ub = longint'({32'b0, b} & mask);
        sa = a[w-1] ? ua - longint'(64'd1 << w) : ua;
        sb = b[w-1] ? ub - longint'(64'd1 << w) : ub;
        r = 0;
        case (op)
            3'd0: r = ua * ub;
            3'd1: if (ub == 0) r = longint'(mask); else r = sa / sb;
            3'd2: if (ub == 0) r = longint'(mask); else r = ua / ub;
            3'd3: if (ub == 0) r = ua; else r = sa % sb;
            3'd4: if (ub == 0) r = ua; else r = ua % ub;
            default: r = 0;
        endcase
        rr = 64'(r) & mask;
        return rr[31:0];
    endfunction

    function automatic logic rdy_of(input bit w8);
        return w8 ? req_rdy8 : req_rdy32;
    endfunction

    function automatic logic val_of(input bit w8);
        return w8 ? resp_val8 : resp_val32;
    endfunction

    function automatic logic [31:0] res_of(input bit w8);
        return w8 ? {24'b0, resp_result8} : resp_result32;
    endfunction

    // One transaction; operands are scrambled right after the handshake.
    task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output logic [31:0] res, output int lat);
        int guard;
        res = '0;
        lat = -1;
        @(negedge clk);
        guard = 0;
        while (!rdy_of(w8) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("req_rdy_timeout", 32'(guard), 32'd0);
            return;
        end
        if (w8) begin
            req_val8 = 1'b1; req_op8 = op; req_a8 = a[7:0]; req_b8 = b[7:0];
        end else begin
            req_val32 = 1'b1; req_op32 = op; req_a32 = a; req_b32 = b;
        end
        @(posedge clk);
        #1;
        req_val8 = 1'b0; req_val32 = 1'b0;
        req_a8 = 8'($urandom); req_b8 = 8'($urandom);
        req_a32 = $urandom; req_b32 = $urandom; req_op32 = 3'($urandom); req_op8 = 3'($urandom);
        lat = 1;
        @(negedge clk);
        while (!val_of(w8) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!val_of(w8)) begin
            check("resp_timeout", 32'(lat), 32'd0);
            return;
        end
        res = res_of(w8);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_a32 = $urandom;
            check("bp_resp_val", 32'(val_of(w8)), 32'd1);
            check("bp_result_stable", res_of(w8), res);
            check("bp_req_rdy", 32'(rdy_of(w8)), 32'd0);
        end
        if (w8) resp_rdy8 = 1'b1; else resp_rdy32 = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy8 = 1'b0; resp_rdy32 = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] res, a, b;
        logic [2:0]  op;
        int lat, seen;

        vecs.push_back('{3'd0, 32'd7,         32'd6,         32'd42});
        vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'd2,         32'hFFFFFFFE});
        vecs.push_back('{3'd1, 32'hFFFFFFEC, 32'd3,         32'hFFFFFFFA});
        vecs.push_back('{3'd3, 32'hFFFFFFEC, 32'd3,         32'hFFFFFFFE});
        vecs.push_back('{3'd2, 32'd20,        32'd3,         32'd6});
        vecs.push_back('{3'd4, 32'd20,        32'd3,         32'd2});
        vecs.push_back('{3'd1, 32'h80000005, 32'd0,         32'hFFFFFFFF});
        vecs.push_back('{3'd2, 32'h80000005, 32'd0,         32'hFFFFFFFF});
        vecs.push_back('{3'd3, 32'h80000005, 32'd0,         32'h80000005});
        vecs.push_back('{3'd4, 32'h80000005, 32'd0,         32'h80000005});
        vecs.push_back('{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{3'd6, 32'd9,         32'd4,         32'd0});
        vecs.push_back('{3'd1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD});

        reset = 1'b0;
        req_val32 = 1'b0; resp_rdy32 = 1'b0; req_op32 = '0; req_a32 = '0; req_b32 = '0;
        req_val8  = 1'b0; resp_rdy8  = 1'b0; req_op8  = '0; req_a8  = '0; req_b8  = '0;
        repeat (2) @(negedge clk);
        check("reset_req_rdy32", 32'(req_rdy32), 32'd1);
        check("reset_resp_val32", 32'(resp_val32), 32'd0);
        check("reset_result32", resp_result32, 32'd0);
        check("reset_req_rdy8", 32'(req_rdy8), 32'd1);
        check("reset_resp_val8", 32'(resp_val8), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
        end

        run_op(1'b0, 3'd0, 32'd7, 32'd6, 10, res, lat);
        check("bp_final_result", res, 32'd42);
        check("bp_idle_req_rdy", 32'(req_rdy32), 32'd1);
        check("bp_idle_resp_val", 32'(resp_val32), 32'd0);

        @(negedge clk);
        req_val32 = 1'b1; req_op32 = 3'd1; req_a32 = 32'd100; req_b32 = 32'd7;
        @(posedge clk);
        #1 req_val32 = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("calc_busy_req_rdy", 32'(req_rdy32), 32'd0);
        reset = 1'b0;
        #1;
        check("async_reset_req_rdy", 32'(req_rdy32), 32'd1);
        check("async_reset_resp_val", 32'(resp_val32), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_val32) seen++;
        end
        check("no_resp_after_reset", 32'(seen), 32'd0);
        run_op(1'b0, 3'd0, 32'd3, 32'd5, 0, res, lat);
        check("mul_after_reset", res, 32'd15);
        check("mul_after_reset_latency", 32'(lat), 32'd33);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 5 == 0) ? 32'd0 : ((i % 7 == 0) ? 32'hFFFFFFFF : $urandom);
            run_op(1'b0, op, a, b, 0, res, lat);
            check("rand32_result", res, ref_model(32, op, a, b));
        end

        for (int i = 0; i < 2000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80;
            case ($urandom_range(0, 5))
                0:       b = 32'h00;
                1:       b = 32'h01;
                2:       b = 32'hFF;
                default: b = $urandom;
            endcase
            run_op(1'b1, op, a, b, 0, res, lat);
            check("sweep8_result", res, ref_model(8, op, a, b));
            check("sweep8_latency", 32'(lat), 32'd9);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
